present_arbiter: RTL and testbench

//  Shares one PRESENT-80 core between two requesters; replaces direct UUT wiring when

---
 rtl/present_arbiter_if.sv | 37 +++
 rtl/present_arbiter.sv | 143 ++++++++++++++
 tb/tb_present_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_arbiter_if.sv
// Requester-side bus of the PRESENT arbiter.
// Both requesters share this bus. Per-requester fields are packed side by side,
// and requester i owns slice i.
//   req_valid_i   [1:0]            request valid, one bit per requester
//   req_ready_o   [1:0]            request accepted when valid & ready
//   req_block_i   [2*BLOCK_W-1:0]  plaintext/ciphertext, requester i at [BLOCK_W*i +: BLOCK_W]
//   req_key_i     [2*KEY_W-1:0]    key, requester i at [KEY_W*i +: KEY_W]
//   req_encdec_i  [1:0]            operation select handed to the core
//   rsp_valid_o   [1:0]            response valid, one-hot to the granted requester
//   rsp_ready_i   [1:0]            response consumed when valid & ready
//   rsp_block_o   [BLOCK_W-1:0]    result block (shared)
//   rsp_err_o                      timeout abort flag
// The master modport is the requester side. The slave modport is the arbiter.
interface present_arbiter_if #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 80
);
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [2*BLOCK_W-1:0] req_block_i;
  logic [2*KEY_W-1:0]   req_key_i;
  logic [1:0]           req_encdec_i;
  logic [1:0]           rsp_valid_o;
  logic [1:0]           rsp_ready_i;
  logic [BLOCK_W-1:0]   rsp_block_o;
  logic                 rsp_err_o;

  modport master (
    output req_valid_i, req_block_i, req_key_i, req_encdec_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_block_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_block_i, req_key_i, req_encdec_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_block_o, rsp_err_o
  );
endinterface

// File: rtl/present_arbiter.sv
// present_arbiter: shares one PRESENT-80 core between two requesters.
// For each request, the arbiter does the following:
//   1. Grants round-robin.
//   2. Registers the operands.
//   3. Holds the core in reset for one LOAD cycle, then releases it.
//   4. Waits for the core's end signal, bounded by TIMEOUT_CYCLES.
//   5. Returns the result to the granted requester.
// The core is held in reset in every state except RUN.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   bus                 requester bus (present_arbiter_if.slave)
//   busy_o              high in any state other than IDLE
//   core_rst_o          core reset, active-high
//   core_enc_dec_o      operation select to the core
//   core_key_o          registered key to the core
//   core_block_o        registered input block to the core
//   core_end_key_gen_i  core key-schedule status (not used for sequencing)
//   core_block_i        core result block
//   core_end_i          core completion flag
module present_arbiter #(
  parameter int BLOCK_W        = 64,
  parameter int KEY_W          = 80,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  present_arbiter_if.slave   bus,
  output logic               busy_o,
  output logic               core_rst_o,
  output logic               core_enc_dec_o,
  output logic [KEY_W-1:0]   core_key_o,
  output logic [BLOCK_W-1:0] core_block_o,
  input  logic               core_end_key_gen_i,
  input  logic [BLOCK_W-1:0] core_block_i,
  input  logic               core_end_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic             winner;
  logic             accept;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] run_cnt;
  logic             timeout_hit;
  logic             unused_ok;

  // Key generation status is informational only.
  assign unused_ok = core_end_key_gen_i;

  // Round-robin pick. A lone requester always wins. When both are valid,
  // the one that was not served last wins.
  always_comb begin
    winner = 1'b0;
    case (bus.req_valid_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  assign accept      = (state == IDLE) && (|bus.req_valid_i);
  assign timeout_hit = (run_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. When end and timeout occur in the same RUN cycle,
  // both lead to RESP, and the datapath gives end priority.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = LOAD;
      LOAD: next_state = RUN;
      RUN:  if (core_end_i || timeout_hit) next_state = RESP;
      RESP: if (bus.rsp_ready_i[grant]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state. Ready and response valid are one-hot
  // to the winner or the grant holder.
  always_comb begin
    bus.req_ready_o = 2'b00;
    bus.rsp_valid_o = 2'b00;
    if (accept) bus.req_ready_o[winner] = 1'b1;
    if (state == RESP) bus.rsp_valid_o[grant] = 1'b1;
    busy_o     = (state != IDLE);
    core_rst_o = (state != RUN);
  end

  // Operand capture, grant tracking, RUN timeout counter and result capture.
  // Operands are written only on accept, so they stay frozen through LOAD and RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key_o      <= '0;
      core_block_o    <= '0;
      core_enc_dec_o  <= 1'b0;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      run_cnt         <= '0;
      bus.rsp_block_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            core_key_o     <= winner ? bus.req_key_i[2*KEY_W-1:KEY_W]
                                     : bus.req_key_i[KEY_W-1:0];
            core_block_o   <= winner ? bus.req_block_i[2*BLOCK_W-1:BLOCK_W]
                                     : bus.req_block_i[BLOCK_W-1:0];
            core_enc_dec_o <= bus.req_encdec_i[winner];
            grant          <= winner;
            last_grant     <= winner;
          end
          run_cnt <= '0;
        end
        LOAD: run_cnt <= '0;
        RUN: begin
          run_cnt <= run_cnt + CNT_W'(1);
          if (core_end_i) begin
            bus.rsp_block_o <= core_block_i;
            bus.rsp_err_o   <= 1'b0;
          end else if (timeout_hit) begin
            bus.rsp_block_o <= '0;
            bus.rsp_err_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_arbiter.sv
// Testbench for present_arbiter.
// A stub PRESENT core answers a small table of known-answer vectors a few
// cycles after it is released from reset. It can also be told to hang so
// that the timeout path is exercised. The stimulus runs as one directed
// sequence, and the expected values are hand-written constants.
module tb_present_arbiter;

  localparam logic ENC = 1'b1;
  localparam logic DEC = 1'b0;
  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] KF = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] PF = {64{1'b1}};
  localparam logic [63:0] C_K0_P0 = 64'h5579C1387B228445;
  localparam logic [63:0] C_KF_P0 = 64'hE72C46C0F5945049;
  localparam logic [63:0] C_K0_PF = 64'hA112FFC72F68417B;
  localparam logic [63:0] C_KF_PF = 64'h3333DCD3213210D2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        core_rst;
  logic        core_enc_dec;
  logic [79:0] core_key;
  logic [63:0] core_block_in;
  logic [63:0] core_block_out;
  logic        core_end;
  logic        stub_hang = 1'b0;
  logic [2:0]  stub_cnt;
  logic        stub_done;
  int          assert_count = 0;
  int          fail_count = 0;

  present_arbiter_if #(.BLOCK_W(64), .KEY_W(80)) bus ();

  present_arbiter #(.BLOCK_W(64), .KEY_W(80), .TIMEOUT_CYCLES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .busy_o             (busy),
    .core_rst_o         (core_rst),
    .core_enc_dec_o     (core_enc_dec),
    .core_key_o         (core_key),
    .core_block_o       (core_block_in),
    .core_end_key_gen_i (1'b0),
    .core_block_i       (core_block_out),
    .core_end_i         (core_end)
  );

  always #5 clk = ~clk;

  // Known-answer lookup standing in for the real cipher.
  function automatic logic [63:0] stubCipher(logic [79:0] key, logic [63:0] blk, logic enc);
    if (enc == ENC && key == K0 && blk == P0) return C_K0_P0;
    if (enc == ENC && key == KF && blk == P0) return C_KF_P0;
    if (enc == ENC && key == K0 && blk == PF) return C_K0_PF;
    if (enc == ENC && key == KF && blk == PF) return C_KF_PF;
    if (enc == DEC && key == KF && blk == C_KF_P0) return P0;
    return 64'hBAD0BAD0BAD0BAD0;
  endfunction

  // Stub core: counts from reset release and raises a sticky end after six cycles.
  // Until then it drives a junk result.
  always_ff @(posedge clk) begin
    if (core_rst) begin
      stub_cnt  <= 3'd0;
      stub_done <= 1'b0;
    end else if (!stub_done && !stub_hang) begin
      if (stub_cnt == 3'd5) stub_done <= 1'b1;
      else                  stub_cnt  <= stub_cnt + 3'd1;
    end
  end

  assign core_end       = stub_done;
  assign core_block_out = stub_done ? stubCipher(core_key, core_block_in, core_enc_dec)
                                    : 64'hA5A5A5A5A5A5A5A5;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [79:0] key,
                               input logic [63:0] blk, input logic enc);
    bus.req_valid_i[idx]          = v;
    bus.req_key_i[80*idx +: 80]   = key;
    bus.req_block_i[64*idx +: 64] = blk;
    bus.req_encdec_i[idx]         = enc;
    #1;
  endtask

  // Presents one request, checks that it is offered ready, lets it be accepted,
  // then scrambles the request inputs to show they no longer matter.
  task automatic issue(input int idx, input logic [79:0] key, input logic [63:0] blk,
                       input logic enc, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = (idx == 0) ? 2'b01 : 2'b10;
    applyStimulus(idx, 1'b1, key, blk, enc);
    checkOutput({tag, "_req_ready"}, 80'(bus.req_ready_o), 80'(exp_rdy));
    tick();
    applyStimulus(idx, 1'b0, ~key, ~blk, ~enc);
  endtask

  task automatic waitResp(input string tag);
    int n;
    n = 0;
    while (bus.rsp_valid_o == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, 80'(bus.rsp_valid_o != 2'b00), 80'd1);
  endtask

  task automatic popResp(input logic [1:0] r);
    bus.rsp_ready_i = r;
    tick();
    bus.rsp_ready_i = 2'b00;
  endtask

  initial begin
    int n;
    int run_cycles;
    int hold_bad;
    int late_rsp;
    logic [1:0] exp_g;
    logic [63:0] exp_blk;

    bus.req_valid_i  = 2'b00;
    bus.req_key_i    = '0;
    bus.req_block_i  = '0;
    bus.req_encdec_i = 2'b00;
    bus.rsp_ready_i  = 2'b00;

    // Reset state
    tick(); tick();
    checkOutput("rst_req_ready", 80'(bus.req_ready_o), 80'd0);
    checkOutput("rst_rsp_valid", 80'(bus.rsp_valid_o), 80'd0);
    checkOutput("rst_rsp_block", 80'(bus.rsp_block_o), 80'd0);
    checkOutput("rst_rsp_err", 80'(bus.rsp_err_o), 80'd0);
    checkOutput("rst_busy", 80'(busy), 80'd0);
    checkOutput("rst_core_rst", 80'(core_rst), 80'd1);
    checkOutput("rst_core_key", core_key, 80'd0);
    checkOutput("rst_core_block", 80'(core_block_in), 80'd0);
    rst = 1'b0;
    tick();

    // Test 1: requester 0, key 0, plaintext 0
    $display("[TB] test 1: req0 encrypt key=0 pt=0");
    issue(0, K0, P0, ENC, "t1");
    checkOutput("t1_load_busy", 80'(busy), 80'd1);
    checkOutput("t1_load_core_rst", 80'(core_rst), 80'd1);
    checkOutput("t1_load_core_key", core_key, K0);
    checkOutput("t1_load_core_enc", 80'(core_enc_dec), 80'(ENC));
    tick();
    checkOutput("t1_run_core_rst", 80'(core_rst), 80'd0);
    n = 0;
    while (!core_end && n < 50) begin tick(); n++; end
    checkOutput("t1_end_seen", 80'(core_end), 80'd1);
    checkOutput("t1_rsp_not_yet", 80'(bus.rsp_valid_o), 80'd0);
    tick();
    checkOutput("t1_rsp_valid", 80'(bus.rsp_valid_o), 80'b01);
    checkOutput("t1_rsp_block", 80'(bus.rsp_block_o), 80'(C_K0_P0));
    checkOutput("t1_rsp_err", 80'(bus.rsp_err_o), 80'd0);
    popResp(2'b01);
    checkOutput("t1_pop_valid", 80'(bus.rsp_valid_o), 80'd0);
    checkOutput("t1_pop_busy", 80'(busy), 80'd0);

    // Test 2: requester 1, all-ones key, encrypt then decrypt
    $display("[TB] test 2: req1 encrypt/decrypt key=all ones");
    issue(1, KF, P0, ENC, "t2e");
    waitResp("t2e");
    checkOutput("t2e_rsp_valid", 80'(bus.rsp_valid_o), 80'b10);
    checkOutput("t2e_rsp_block", 80'(bus.rsp_block_o), 80'(C_KF_P0));
    popResp(2'b10);
    issue(1, KF, C_KF_P0, DEC, "t2d");
    waitResp("t2d");
    checkOutput("t2d_rsp_valid", 80'(bus.rsp_valid_o), 80'b10);
    checkOutput("t2d_rsp_block", 80'(bus.rsp_block_o), 80'(P0));

    // Test 5: the response is held for 10 cycles. Only the non-granted
    // ready bit is high, and requester 0 is waiting.
    $display("[TB] test 5: response held while rsp_ready withheld");
    applyStimulus(0, 1'b1, K0, P0, ENC);
    bus.rsp_ready_i = 2'b01;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid_o !== 2'b10 || bus.rsp_block_o !== P0 ||
          bus.rsp_err_o !== 1'b0 || bus.req_ready_o !== 2'b00) hold_bad++;
    end
    checkOutput("t5_hold_stable", 80'(hold_bad), 80'd0);
    checkOutput("t5_req_ready", 80'(bus.req_ready_o), 80'd0);
    applyStimulus(0, 1'b0, K0, P0, ENC);
    popResp(2'b10);
    checkOutput("t5_pop_valid", 80'(bus.rsp_valid_o), 80'd0);

    // Test 3: both requesters valid for four operations
    $display("[TB] test 3: contention round robin");
    applyStimulus(0, 1'b1, K0, PF, ENC);
    applyStimulus(1, 1'b1, KF, PF, ENC);
    for (int op = 0; op < 4; op++) begin
      exp_g   = (op % 2 == 0) ? 2'b01 : 2'b10;
      exp_blk = (op % 2 == 0) ? C_K0_PF : C_KF_PF;
      checkOutput($sformatf("t3_op%0d_ready", op), 80'(bus.req_ready_o), 80'(exp_g));
      tick();
      waitResp($sformatf("t3_op%0d", op));
      checkOutput($sformatf("t3_op%0d_valid", op), 80'(bus.rsp_valid_o), 80'(exp_g));
      checkOutput($sformatf("t3_op%0d_block", op), 80'(bus.rsp_block_o), 80'(exp_blk));
      popResp(2'b11);
    end
    applyStimulus(0, 1'b0, K0, PF, ENC);
    applyStimulus(1, 1'b0, KF, PF, ENC);

    // Test 4: the core hangs, so the request times out after 16 RUN cycles.
    $display("[TB] test 4: timeout");
    stub_hang = 1'b1;
    issue(1, KF, P0, ENC, "t4");
    run_cycles = 0;
    n = 0;
    while (bus.rsp_valid_o == 2'b00 && n < 100) begin
      if (core_rst == 1'b0) run_cycles++;
      tick();
      n++;
    end
    checkOutput("t4_run_cycles", 80'(run_cycles), 80'd16);
    checkOutput("t4_rsp_valid", 80'(bus.rsp_valid_o), 80'b10);
    checkOutput("t4_rsp_err", 80'(bus.rsp_err_o), 80'd1);
    checkOutput("t4_rsp_block", 80'(bus.rsp_block_o), 80'd0);
    popResp(2'b10);
    stub_hang = 1'b0;
    issue(0, K0, P0, ENC, "t4n");
    waitResp("t4n");
    checkOutput("t4n_rsp_block", 80'(bus.rsp_block_o), 80'(C_K0_P0));
    checkOutput("t4n_rsp_err", 80'(bus.rsp_err_o), 80'd0);
    popResp(2'b01);

    // Test 6: reset in the middle of RUN
    $display("[TB] test 6: reset during RUN");
    issue(1, KF, P0, ENC, "t6");
    tick();
    checkOutput("t6_run_core_rst", 80'(core_rst), 80'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_core_rst", 80'(core_rst), 80'd1);
    checkOutput("t6_rsp_valid", 80'(bus.rsp_valid_o), 80'd0);
    checkOutput("t6_busy", 80'(busy), 80'd0);
    rst = 1'b0;
    late_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid_o != 2'b00) late_rsp++;
    end
    checkOutput("t6_no_late_rsp", 80'(late_rsp), 80'd0);
    applyStimulus(0, 1'b1, K0, P0, ENC);
    applyStimulus(1, 1'b1, KF, P0, ENC);
    checkOutput("t6_rr_reset_ready", 80'(bus.req_ready_o), 80'b01);
    tick();
    applyStimulus(0, 1'b0, K0, P0, ENC);
    applyStimulus(1, 1'b0, KF, P0, ENC);
    waitResp("t6n");
    checkOutput("t6n_rsp_valid", 80'(bus.rsp_valid_o), 80'b01);
    checkOutput("t6n_rsp_block", 80'(bus.rsp_block_o), 80'(C_K0_P0));
    popResp(2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
